// File: rtl/core_fetch_pkg.sv
// Shared fetch-side types and constants used by the instruction queue and its FIFO.
package core_fetch_pkg;

  localparam int PC_W       = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  // An entry stores only the word; its PC is implied by its position behind the head.
  typedef struct packed {
    logic [INST_W-1:0] word;
  } iq_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/inst_queue_fifo.sv
// Circular word buffer with push/pop/flush, an occupancy count and a two-entry
// read lookahead (head and head+1).
module inst_queue_fifo
  import core_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  iq_entry_t     push_entry,
  input  logic          pop,
  input  logic          flush,
  output iq_entry_t     head_entry,
  output iq_entry_t     next_entry,
  output logic [CW-1:0] count
);

  iq_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign next_entry = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/inst_queue.sv
// Fetch-side instruction queue feeding decode: credit-limited sequential fetch,
// stale-response discard after redirect, and long-immediate tracking.
// Optional same-cycle response bypass when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue
  import core_fetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst_n,
  output logic              f2ic_req,
  output logic [PC_W-1:0]   f2ic_addr,
  input  logic              ic2f_gnt,
  input  logic              ic2f_rvalid,
  input  logic [INST_W-1:0] ic2f_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              d2f_dep_stall,
  input  logic              d2f_long_imm,
  output logic [INST_W-1:0] f2d_inst,
  output logic [INST_W-1:0] f2d_nextinst,
  output logic              f2d_valid,
  output logic [PC_W-1:0]   f2d_pc,
  output logic              f2d_prev_long_imm
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [CW-1:0]     count;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     stale;
  logic [OW-1:0]     stale_redir;
  logic [OW:0]       stale_base;
  logic [SW-1:0]     in_use;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   head_pc;
  logic [PC_W-1:0]   redirect_target;
  logic [INST_W-1:0] inst_hold;
  logic [INST_W-1:0] head_word;
  logic              prev_long_imm;
  logic              grant;
  logic              rsp_live;
  logic              rsp_drop;
  logic              head_valid;
  logic              next_valid;
  logic              bypass_hit;
  logic              adv;
  logic              fifo_push;
  logic              fifo_pop;
  iq_entry_t         rsp_entry;
  iq_entry_t         head_entry;
  iq_entry_t         next_entry;

  assign rsp_live        = ic2f_rvalid & (stale == '0);
  assign rsp_drop        = ic2f_rvalid & (stale != '0);
  assign in_use          = SW'(count) + SW'(outstanding);
  assign redirect_target = word_align(redirect_pc);

  // Requests are held off during reset and whenever buffer space is already promised.
  assign f2ic_req  = clkrst_core_rst_n & ~redirect & (in_use < SW'(DEPTH))
                   & (outstanding < OW'(MAX_OUTST));
  assign f2ic_addr = fetch_pc;
  assign grant     = f2ic_req & ic2f_gnt;

  assign head_valid = (count != '0);
  assign next_valid = (count > CW'(1));

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass_hit = (count == '0) & rsp_live;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_word         = bypass_hit ? ic2f_rdata : head_entry.word;
  assign f2d_valid         = head_valid | bypass_hit;
  assign f2d_inst          = f2d_valid ? head_word : inst_hold;
  assign f2d_nextinst      = next_valid ? next_entry.word : '0;
  assign f2d_pc            = head_pc;
  assign f2d_prev_long_imm = prev_long_imm;

  // A long-immediate instruction waits until its immediate word is buffered behind it.
  assign adv       = f2d_valid & ~d2f_dep_stall & ~(d2f_long_imm & ~next_valid);
  assign fifo_push = rsp_live & ~(bypass_hit & adv);
  assign fifo_pop  = adv & head_valid;
  assign rsp_entry = '{word: ic2f_rdata};

  inst_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clkrst_core_clk),
    .rst_n      (clkrst_core_rst_n),
    .push       (fifo_push),
    .push_entry (rsp_entry),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head_entry (head_entry),
    .next_entry (next_entry),
    .count      (count)
  );

  // On redirect every response still in flight becomes stale, less the one landing now.
  always_comb begin
    stale_base  = {1'b0, stale} + {1'b0, outstanding};
    stale_redir = stale;
    if (ic2f_rvalid && (stale_base != '0)) stale_base = stale_base - (OW+1)'(1);
    if (stale_base > (OW+1)'(MAX_OUTST)) stale_redir = OW'(MAX_OUTST);
    else                                 stale_redir = stale_base[OW-1:0];
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      fetch_pc      <= '0;
      head_pc       <= '0;
      outstanding   <= '0;
      stale         <= '0;
      prev_long_imm <= 1'b0;
    end else if (redirect) begin
      fetch_pc      <= redirect_target;
      head_pc       <= redirect_target;
      outstanding   <= '0;
      stale         <= stale_redir;
      prev_long_imm <= 1'b0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + PC_W'(INST_BYTES);
      if (adv) begin
        head_pc       <= head_pc + PC_W'(INST_BYTES);
        prev_long_imm <= d2f_long_imm & ~prev_long_imm;
      end
      outstanding <= outstanding + OW'(grant) - OW'(rsp_live);
      if (rsp_drop) stale <= stale - OW'(1);
    end
  end

  // Decode keeps seeing the last presented word while the queue is empty.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) inst_hold <= '0;
    else if (f2d_valid)     inst_hold <= head_word;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a tagged-epoch memory model feeds responses,
// and a monitor compares decode-side and fetch-side outputs every cycle.
module tb_inst_queue;
  import core_fetch_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f2ic_req;
  logic [31:0] f2ic_addr;
  logic        ic2f_gnt = 1'b0;
  logic        ic2f_rvalid = 1'b0;
  logic [31:0] ic2f_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        d2f_dep_stall = 1'b0;
  logic        d2f_long_imm = 1'b0;
  logic [31:0] f2d_inst;
  logic [31:0] f2d_nextinst;
  logic        f2d_valid;
  logic [31:0] f2d_pc;
  logic        f2d_prev_long_imm;

  int          errors = 0;
  int          checks = 0;
  int          consumed = 0;
  bit          running = 1'b0;
  req_t        pending[$];
  logic [31:0] sb_pc[$];
  logic [31:0] cur_epoch = '0;
  logic [31:0] exp_fetch_pc = '0;
  bit          exp_prev = 1'b0;
  bit          adv_q = 1'b0;
  bit          req_q = 1'b0;
  bit          byp_taken = 1'b0;

  inst_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .f2ic_req          (f2ic_req),
    .f2ic_addr         (f2ic_addr),
    .ic2f_gnt          (ic2f_gnt),
    .ic2f_rvalid       (ic2f_rvalid),
    .ic2f_rdata        (ic2f_rdata),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .d2f_dep_stall     (d2f_dep_stall),
    .d2f_long_imm      (d2f_long_imm),
    .f2d_inst          (f2d_inst),
    .f2d_nextinst      (f2d_nextinst),
    .f2d_valid         (f2d_valid),
    .f2d_pc            (f2d_pc),
    .f2d_prev_long_imm (f2d_prev_long_imm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'hC001D00D;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory side plus decode-side stimulus, driven 2 time units after each rising edge.
  task automatic applyStimulus(input int cycles, input int gnt_pct, input int rv_pct,
                               input int stall_pct, input int li_pct, input int redir_pct,
                               input logic [31:0] target, input bit rand_target);
    repeat (cycles) begin
      @(posedge clk);
      #2;
      ic2f_gnt      = ($urandom_range(99) < gnt_pct) && (pending.size() < MAX_OUTST);
      ic2f_rvalid   = (pending.size() > 0) && ($urandom_range(99) < rv_pct);
      ic2f_rdata    = ic2f_rvalid ? word_of(pending[0].addr) : $urandom;
      d2f_dep_stall = ($urandom_range(99) < stall_pct);
      d2f_long_imm  = ($urandom_range(99) < li_pct);
      redirect      = ($urandom_range(99) < redir_pct);
      redirect_pc   = rand_target ? $urandom : target;
    end
  endtask

  // Monitor: compares everything decode and the memory port see this cycle.
  always @(negedge clk) begin
    int          q_size;
    int          outst;
    bit          ev;
    bit          env;
    bit          byp;
    bit          eadv;
    logic [31:0] epc;
    if (running) begin
      q_size = sb_pc.size();
      outst  = 0;
      foreach (pending[i]) if (pending[i].epoch == cur_epoch) outst++;
      byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      byp = (q_size == 0) && ic2f_rvalid && (pending.size() > 0) && (pending[0].epoch == cur_epoch);
`endif
      ev    = (q_size > 0) || byp;
      env   = (q_size > 1);
      epc   = (q_size > 0) ? sb_pc[0] : (byp ? pending[0].addr : 32'h0);
      req_q = !redirect && (q_size + outst < DEPTH) && (outst < MAX_OUTST);
      checkOutput("req", {31'b0, f2ic_req}, {31'b0, req_q});
      if (req_q) checkOutput("addr", f2ic_addr, exp_fetch_pc);
      checkOutput("valid", {31'b0, f2d_valid}, {31'b0, ev});
      if (ev) begin
        checkOutput("pc", f2d_pc, epc);
        checkOutput("inst", f2d_inst, word_of(epc));
      end
      checkOutput("nextinst", f2d_nextinst, env ? word_of(sb_pc[1]) : 32'h0);
      checkOutput("prev_long_imm", {31'b0, f2d_prev_long_imm}, {31'b0, exp_prev});
      if (dut.u_fifo.push) checkOutput("push_at_full", {31'b0, dut.u_fifo.count == DEPTH}, 32'h0);
      eadv = ev && !d2f_dep_stall && !(d2f_long_imm && !env);
      if (eadv) begin
        consumed++;
        if (q_size > 0) void'(sb_pc.pop_front());
        else            byp_taken = 1'b1;
      end
      adv_q = eadv;
    end
  end

  // Reference model: memory returns words in order, tagged with the redirect epoch
  // they were requested in; only current-epoch words reach decode.
  always @(posedge clk) begin
    req_t p;
    if (running) begin
      if (ic2f_rvalid) begin
        p = pending.pop_front();
        if ((p.epoch == cur_epoch) && !byp_taken) sb_pc.push_back(p.addr);
      end
      if (req_q && ic2f_gnt) begin
        p.addr  = exp_fetch_pc;
        p.epoch = cur_epoch;
        pending.push_back(p);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (adv_q) exp_prev = d2f_long_imm && !exp_prev;
      if (redirect) begin
        sb_pc.delete();
        exp_prev     = 1'b0;
        cur_epoch    = cur_epoch + 32'd1;
        exp_fetch_pc = redirect_pc & ~32'h3;
      end
      byp_taken = 1'b0;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'b0, f2ic_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, f2d_valid}, 32'h0);
    checkOutput("rst_prev", {31'b0, f2d_prev_long_imm}, 32'h0);
    checkOutput("rst_inst", f2d_inst, 32'h0);
    checkOutput("rst_nextinst", f2d_nextinst, 32'h0);
    checkOutput("rst_pc", f2d_pc, 32'h0);
    checkOutput("rst_addr", f2ic_addr, 32'h0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    running = 1'b1;

    applyStimulus(12, 100, 100, 0, 0, 0, 32'h0, 1'b0);
    applyStimulus(8, 100, 100, 100, 0, 0, 32'h0, 1'b0);
    applyStimulus(40, 60, 50, 20, 50, 0, 32'h0, 1'b0);
    applyStimulus(4, 100, 0, 100, 0, 0, 32'h0, 1'b0);
    applyStimulus(1, 0, 0, 100, 0, 100, 32'h1002, 1'b0);
    applyStimulus(20, 100, 100, 0, 0, 0, 32'h0, 1'b0);
    applyStimulus(10, 100, 100, 0, 100, 30, 32'h2000, 1'b0);
    applyStimulus(3000, 70, 60, 25, 30, 4, 32'h0, 1'b1);
    applyStimulus(20, 0, 100, 0, 0, 0, 32'h0, 1'b0);

    @(posedge clk);
    #2;
    running = 1'b0;
    @(negedge clk);
    checkOutput("progress", {31'b0, consumed > 100}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
